// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic {
        StRun,
        StHalt
    } fetch_state_e;

    localparam int unsigned INSN_BYTES = 4;
    localparam logic [31:0] ZERO_INSN  = 32'h0000_0000;

endpackage

// File: rtl/fetch_slot.sv
// One-entry output register toward decode: load takes priority over flush, otherwise hold.
module fetch_slot #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_load,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_pc
);

    logic            r_valid;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_pc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, feeds a one-entry slot, handles redirects and halts.
// Optional: define FETCH_HALT_ON_ZERO_EN to treat an all-zero ROM word as end-of-program.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned     ADDR_W   = 5,
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [XLEN-1:0]   i_rom_data,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [XLEN-1:0]   o_inst,
    output logic [XLEN-1:0]   o_inst_pc,
    input  logic              i_redirect_valid,
    input  logic [XLEN-1:0]   i_redirect_pc,
    output logic              o_halted,
    output logic              o_fault,
    output logic [31:0]       o_fetch_count
);

    localparam int unsigned PcLsb = $clog2(INSN_BYTES);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic            r_fault;
    logic            w_fault_next;
    logic [31:0]     r_count;

    logic            w_free;
    logic            w_handshake;
    logic            w_out_of_range;
    logic            w_zero_insn;
    logic            w_load;
    logic            w_flush;

    assign w_free         = !o_inst_valid || i_inst_ready;
    assign w_handshake    = o_inst_valid && i_inst_ready;
    // Any bit above the ROM window means the PC has run past the last word.
    assign w_out_of_range = |r_pc[XLEN-1:ADDR_W+PcLsb];

`ifdef FETCH_HALT_ON_ZERO_EN
    assign w_zero_insn = (i_rom_data == ZERO_INSN);
`else
    assign w_zero_insn = 1'b0;
`endif

    always_comb begin
        w_pc_next    = r_pc;
        w_state_next = r_state;
        w_fault_next = r_fault;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        if (i_redirect_valid) begin
            w_pc_next    = {i_redirect_pc[XLEN-1:PcLsb], {PcLsb{1'b0}}};
            w_state_next = StRun;
            w_flush      = 1'b1;
            if (|i_redirect_pc[PcLsb-1:0]) begin
                w_fault_next = 1'b1;
            end
        end else if (r_state == StRun && w_free) begin
            if (w_out_of_range) begin
                w_fault_next = 1'b1;
                w_state_next = StHalt;
                w_flush      = 1'b1;
            end else if (w_zero_insn) begin
                w_state_next = StHalt;
                w_flush      = 1'b1;
            end else begin
                w_load    = 1'b1;
                w_pc_next = r_pc + XLEN'(INSN_BYTES);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StRun;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_fault <= w_fault_next;
            r_count <= r_count + {31'b0, w_handshake};
        end
    end

    fetch_slot #(
        .XLEN (XLEN)
    ) u_slot (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_inst  (i_rom_data),
        .i_pc    (r_pc),
        .o_valid (o_inst_valid),
        .o_inst  (o_inst),
        .o_pc    (o_inst_pc)
    );

    assign o_rom_addr    = r_pc[ADDR_W+PcLsb-1:PcLsb];
    assign o_halted      = (r_state == StHalt);
    assign o_fault       = r_fault;
    assign o_fetch_count = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal checks, then random traffic
// checked every cycle against a behavioural model.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic [4:0]  rom_addr;
    logic [31:0] rom_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    logic [31:0] rom [32];
    assign rom_data = rom[rom_addr];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    fetch_sequencer dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .o_rom_addr       (rom_addr),
        .i_rom_data       (rom_data),
        .o_inst_valid     (inst_valid),
        .i_inst_ready     (inst_ready),
        .o_inst           (inst),
        .o_inst_pc        (inst_pc),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_halted         (halted),
        .o_fault          (fault),
        .o_fetch_count    (fetch_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Behavioural model: architectural view of the sequencer.
    logic [31:0] m_pc, m_inst, m_ipc, m_cnt;
    bit          m_valid, m_halted, m_fault;

    always @(posedge clk) begin
        bit hs, free;
        logic [31:0] word;
        if (rst) begin
            m_pc = 0; m_inst = 0; m_ipc = 0; m_cnt = 0;
            m_valid = 0; m_halted = 0; m_fault = 0;
        end else begin
            hs   = m_valid && inst_ready;
            free = !m_valid || inst_ready;
            if (hs) m_cnt = m_cnt + 1;
            if (redirect_valid) begin
                if (redirect_pc % 4 != 0) m_fault = 1;
                m_pc     = redirect_pc - (redirect_pc % 4);
                m_valid  = 0;
                m_halted = 0;
            end else if (!m_halted && free) begin
                if (m_pc >= 32 * 4) begin
                    m_fault  = 1;
                    m_halted = 1;
                    m_valid  = 0;
                end else begin
                    word = rom[m_pc / 4];
`ifdef FETCH_HALT_ON_ZERO_EN
                    if (word == 0) begin
                        m_valid  = 0;
                        m_halted = 1;
                    end else begin
                        m_inst = word; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 4;
                    end
`else
                    m_inst = word; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 4;
`endif
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m.valid", {31'b0, inst_valid}, {31'b0, m_valid});
            check("m.halted", {31'b0, halted}, {31'b0, m_halted});
            check("m.fault", {31'b0, fault}, {31'b0, m_fault});
            check("m.count", fetch_count, m_cnt);
            check("m.rom_addr", {27'b0, rom_addr}, {27'b0, m_pc[6:2]});
            if (m_valid) begin
                check("m.inst", inst, m_inst);
                check("m.inst_pc", inst_pc, m_ipc);
            end
        end
    end

    task automatic cyc(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc);
        rst            = r;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = $urandom | 32'h1;
        rom[0]  = 32'h0030_0413;
        rom[1]  = 32'h0010_0493;
        rom[2]  = 32'h0100_0913;
        rom[30] = 32'h0000_0000;
        rom[31] = 32'h0000_0073;

        rst = 1; inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        cyc(1, 0, 0, 0);
        check("rst.valid", {31'b0, inst_valid}, 32'd0);
        check("rst.count", fetch_count, 32'd0);
        check("rst.inst", inst, 32'd0);
        check("rst.halted", {31'b0, halted}, 32'd0);

        // Streaming with ready held high.
        cyc(0, 1, 0, 0);
        check("s1.inst", inst, 32'h0030_0413);
        check("s1.pc", inst_pc, 32'h0);
        cyc(0, 1, 0, 0);
        check("s2.inst", inst, 32'h0010_0493);
        check("s2.pc", inst_pc, 32'h4);
        cyc(0, 1, 0, 0);
        check("s3.inst", inst, 32'h0100_0913);
        check("s3.pc", inst_pc, 32'h8);
        cyc(0, 1, 0, 0);
        check("s3.count_after_third_accept", fetch_count, 32'd3);
        cyc(0, 1, 0, 0);
        check("bp.pc_before", inst_pc, 32'h10);

        // Backpressure: everything holds.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            check("bp.pc", inst_pc, 32'h10);
            check("bp.rom_addr", {27'b0, rom_addr}, 32'd5);
            check("bp.count", fetch_count, 32'd4);
        end
        cyc(0, 1, 0, 0);
        check("bp.release_pc", inst_pc, 32'h14);
        check("bp.release_count", fetch_count, 32'd5);

        // Redirect while a handshake happens.
        cyc(0, 1, 1, 32'h0C);
        check("rd.flush", {31'b0, inst_valid}, 32'd0);
        check("rd.count", fetch_count, 32'd6);
        cyc(0, 1, 0, 0);
        check("rd.pc", inst_pc, 32'h0C);

        // Misaligned redirect.
        cyc(0, 1, 1, 32'h0E);
        check("mis.fault", {31'b0, fault}, 32'd1);
        cyc(0, 1, 0, 0);
        check("mis.pc", inst_pc, 32'h0C);
        check("mis.count", fetch_count, 32'd7);

        // Reset during a stall.
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("rs.valid", {31'b0, inst_valid}, 32'd0);
        check("rs.count", fetch_count, 32'd0);
        check("rs.fault", {31'b0, fault}, 32'd0);
        check("rs.inst_pc", inst_pc, 32'd0);
        check("rs.rom_addr", {27'b0, rom_addr}, 32'd0);

        // Zero word at 0x78.
        cyc(0, 1, 1, 32'h70);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("z.pc74", inst_pc, 32'h74);
        cyc(0, 1, 0, 0);
`ifdef FETCH_HALT_ON_ZERO_EN
        check("z.valid", {31'b0, inst_valid}, 32'd0);
        check("z.halted", {31'b0, halted}, 32'd1);
        check("z.fault", {31'b0, fault}, 32'd0);
`else
        check("z.valid", {31'b0, inst_valid}, 32'd1);
        check("z.inst", inst, 32'h0);
        check("z.pc78", inst_pc, 32'h78);
`endif

        // Last word and running off the end.
        cyc(0, 1, 1, 32'h7C);
        cyc(0, 1, 0, 0);
        check("end.pc", inst_pc, 32'h7C);
        check("end.inst", inst, 32'h0000_0073);
        cyc(0, 1, 0, 0);
        check("end.halted", {31'b0, halted}, 32'd1);
        check("end.fault", {31'b0, fault}, 32'd1);
        check("end.valid", {31'b0, inst_valid}, 32'd0);
        cyc(0, 1, 1, 32'h0);
        check("res.halted", {31'b0, halted}, 32'd0);
        cyc(0, 1, 0, 0);
        check("res.inst", inst, 32'h0030_0413);
        check("res.fault", {31'b0, fault}, 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 19) == 0), 32'($urandom_range(0, 160)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
